// File: rtl/mtm_alu_deserializer.sv
// Serial front end of the mtm_Alu: decodes 11-bit frames on sin, assembles
// the {B,A} operands and the CMD byte, and flags data/CRC/opcode errors.
module mtm_alu_deserializer #(
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_A,
    output logic [31:0] out_B,
    output logic [2:0]  out_op,
    output logic [2:0]  out_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TYPE      = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(8);

    localparam logic [2:0] ERR_NONE = 3'b000;
    localparam logic [2:0] ERR_DATA = 3'b100;
    localparam logic [2:0] ERR_CRC  = 3'b010;
    localparam logic [2:0] ERR_OP   = 3'b001;

    // Serial LFSR for x^4+x+1, unrolled over the whole message.
    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'd0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2], c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    logic             sin_meta_q, sin_meta_d;
    logic             sin_s_q, sin_s_d;
    logic [2:0]       state_q, state_d;
    logic             is_cmd_q, is_cmd_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [63:0]      ba_q, ba_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       out_err_q, out_err_d;
    logic [31:0]      out_a_q, out_a_d;
    logic [31:0]      out_b_q, out_b_d;
    logic [2:0]       out_op_q, out_op_d;

    logic [2:0] cmd_op;
    logic [3:0] crc_calc;
    logic       op_ok;

    assign cmd_op   = byte_q[6:4];
    assign crc_calc = crc4({ba_q, 1'b1, cmd_op});
    assign op_ok    = (cmd_op == 3'b000) || (cmd_op == 3'b001) ||
                      (cmd_op == 3'b100) || (cmd_op == 3'b101);

    always_comb begin
        sin_meta_d  = sin;
        sin_s_d     = sin_meta_q;
        state_d     = state_q;
        is_cmd_d    = is_cmd_q;
        bit_cnt_d   = bit_cnt_q;
        byte_d      = byte_q;
        frame_cnt_d = frame_cnt_q;
        ba_d        = ba_q;
        out_valid_d = 1'b0;
        out_err_d   = ERR_NONE;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_op_d    = out_op_q;

        case (state_q)
            S_IDLE: begin
                if (!sin_s_q) state_d = S_TYPE;
            end
            S_TYPE: begin
                is_cmd_d  = sin_s_q;
                bit_cnt_d = 3'd0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                byte_d    = {byte_q[6:0], sin_s_q};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = S_STOP;
            end
            S_STOP: begin
                state_d = sin_s_q ? S_IDLE : S_WAIT_HIGH;
                if (!sin_s_q || (!is_cmd_q && frame_cnt_q >= FULL_CNT) ||
                    (is_cmd_q && frame_cnt_q != FULL_CNT)) begin
                    out_valid_d = 1'b1;
                    out_err_d   = ERR_DATA;
                end else if (!is_cmd_q) begin
                    ba_d        = {ba_q[55:0], byte_q};
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end else if (crc_calc != byte_q[3:0]) begin
                    out_valid_d = 1'b1;
                    out_err_d   = ERR_CRC;
                end else if (!op_ok) begin
                    out_valid_d = 1'b1;
                    out_err_d   = ERR_OP;
                end else begin
                    out_valid_d = 1'b1;
                    out_b_d     = ba_q[63:32];
                    out_a_d     = ba_q[31:0];
                    out_op_d    = cmd_op;
                end
                // Every pulse, good or bad, ends the current packet.
                if (out_valid_d) begin
                    frame_cnt_d = '0;
                    ba_d        = 64'd0;
                end
            end
            S_WAIT_HIGH: begin
                if (sin_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sin_meta_q  <= 1'b1;
            sin_s_q     <= 1'b1;
            state_q     <= S_IDLE;
            is_cmd_q    <= 1'b0;
            bit_cnt_q   <= 3'd0;
            byte_q      <= 8'd0;
            frame_cnt_q <= '0;
            ba_q        <= 64'd0;
            out_valid_q <= 1'b0;
            out_err_q   <= ERR_NONE;
            out_a_q     <= 32'd0;
            out_b_q     <= 32'd0;
            out_op_q    <= 3'd0;
        end else begin
            sin_meta_q  <= sin_meta_d;
            sin_s_q     <= sin_s_d;
            state_q     <= state_d;
            is_cmd_q    <= is_cmd_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_q      <= byte_d;
            frame_cnt_q <= frame_cnt_d;
            ba_q        <= ba_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_op_q    <= out_op_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign out_A     = out_a_q;
    assign out_B     = out_b_q;
    assign out_op    = out_op_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Scoreboard bench for mtm_alu_deserializer: frames are driven bit by bit and
// each expected pulse (code, operands, arrival cycle) is queued for the monitor.
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic        out_valid;
    logic [31:0] out_A;
    logic [31:0] out_B;
    logic [2:0]  out_op;
    logic [2:0]  out_err;

    mtm_alu_deserializer #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .out_valid (out_valid),
        .out_A     (out_A),
        .out_B     (out_B),
        .out_op    (out_op),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  err;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mdl_a = 32'd0;
    logic [31:0] mdl_b = 32'd0;
    logic [2:0]  mdl_op = 3'd0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Remainder of (msg * x^4) mod (x^4+x+1) by long division.
    function automatic logic [3:0] crc4_model(input logic [67:0] msg);
        logic [71:0] r;
        r = {msg, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Called right after the final stop bit: that bit was sampled at the last edge.
    task automatic expect_pulse(input logic [2:0] err);
        exp_t e;
        e.err = err;
        e.a   = mdl_a;
        e.b   = mdl_b;
        e.op  = mdl_op;
        e.cyc = cyc + 2;
        sb_q.push_back(e);
    endtask

    task automatic send_packet(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic [3:0] crc_flip);
        logic [3:0] crc;
        for (int i = 0; i < 4; i++) send_frame(1'b0, b[31 - 8*i -: 8], 1'b1);
        for (int i = 0; i < 4; i++) send_frame(1'b0, a[31 - 8*i -: 8], 1'b1);
        crc = crc4_model({b, a, 1'b1, op}) ^ crc_flip;
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
        if (crc_flip != 4'd0) begin
            expect_pulse(3'b010);
        end else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
            expect_pulse(3'b001);
        end else begin
            mdl_a  = a;
            mdl_b  = b;
            mdl_op = op;
            expect_pulse(3'b000);
        end
        send_bit(1'b1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                $display("pulse cyc=%0d err=%b A=%h B=%h op=%b", cyc, out_err, out_A, out_B, out_op);
                if (sb_q.size() == 0) begin
                    check("spurious_pulse", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_err", 64'(out_err), 64'(mon_e.err));
                    check("out_A", 64'(out_A), 64'(mon_e.a));
                    check("out_B", 64'(out_B), 64'(mon_e.b));
                    check("out_op", 64'(out_op), 64'(mon_e.op));
                    check("latency", 64'(cyc), 64'(mon_e.cyc));
                end
            end else begin
                check("err_idle", 64'(out_err), 64'd0);
            end
        end
    end

    localparam logic [2:0] GOOD_OPS [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_A", 64'(out_A), 64'd0);
        check("rst_B", 64'(out_B), 64'd0);
        check("rst_op", 64'(out_op), 64'd0);
        rst_n = 1'b1;
        repeat (3) send_bit(1'b1);

        send_packet(32'hFFFFFFFF, 32'h00000000, 3'b100, 4'd0);
        for (int i = 0; i < 4; i++)
            send_packet(32'h12345678 + i, 32'h9ABCDEF0 ^ i, GOOD_OPS[i], 4'd0);

        send_packet(32'hAAAAAAAA, 32'hAAAAAAAA, 3'b010, 4'd0);
        send_packet(32'hAAAAAAAA, 32'hAAAAAAAA, 3'b000, 4'b0001);
        send_packet(32'hAAAAAAAA, 32'hAAAAAAAA, 3'b110, 4'b0100);

        for (int n = 1; n <= 7; n++) begin
            for (int k = 0; k < n; k++) send_frame(1'b0, 8'hAA, 1'b1);
            send_frame(1'b1, 8'h00, 1'b1);
            expect_pulse(3'b100);
            send_bit(1'b1);
        end

        for (int k = 0; k < 9; k++) send_frame(1'b0, 8'hAA, 1'b1);
        expect_pulse(3'b100);
        repeat (3) send_bit(1'b1);

        send_frame(1'b0, 8'h55, 1'b0);
        expect_pulse(3'b100);
        repeat (5) send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        send_packet(32'hCAFEF00D, 32'h0BADBEEF, 3'b101, 4'd0);

        for (int k = 0; k < 4; k++) send_frame(1'b0, 8'h5A, 1'b1);
        rst_n = 1'b0;
        send_bit(1'b1);
        rst_n = 1'b1;
        mdl_a  = 32'd0;
        mdl_b  = 32'd0;
        mdl_op = 3'd0;
        check("mid_rst_A", 64'(out_A), 64'd0);
        check("mid_rst_op", 64'(out_op), 64'd0);
        send_bit(1'b1);
        send_packet(32'h01020304, 32'hA0B0C0D0, 3'b001, 4'd0);

        for (int i = 0; i < 200; i++)
            send_packet($urandom, $urandom, GOOD_OPS[i % 4], 4'd0);

        repeat (6) send_bit(1'b1);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
